pc_sequencer: RTL
=================

# pc_sequencer

- Microsequencer program-counter block for the CtrlPIM controller.
- Consumes the 2-bit next-address select `{s1, s0}` produced by the controller's address-select decode logic.
- Holds the program counter and drives the instruction-fetch handshake towards instruction memory.
- Optionally keeps a small return-address stack for call/return microinstructions.

## Interface
Parameters:
- ADDR_W, 8, width of program counter and all address ports
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2); only used with stack enabled

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s1  in  1  next-address select, MSB
- s0  in  1  next-address select, LSB
- step  in  1  one-cycle strobe: current instruction done, apply `{s1,s0}`
- branch_addr  in  ADDR_W  branch target from instruction operand
- indirect_addr  in  ADDR_W  register-sourced target
- start_addr  in  ADDR_W  program start address
- call  in  1  qualifies a step with sel=01 as a call
- ret  in  1  qualifies a step as a return
- fetch_valid  out  1  fetch request valid
- fetch_addr  out  ADDR_W  fetch address (equals pc)
- fetch_ready  in  1  instruction memory accepts the request
- pc  out  ADDR_W  current program counter
- busy  out  1  high in FETCH or EXEC
- seq_err  out  1  sticky: step received outside EXEC
- stack_err  out  1  sticky: stack overflow or underflow

## Operation
- Select encoding:
  - 00: pc+1, modulo 2^ADDR_W; wraps from all-ones to 0 with no flag.
  - 01: branch_addr.
  - 10: indirect_addr.
  - 11: start_addr, which also restarts the sequencer.
- States: IDLE, FETCH, EXEC.
  - IDLE: fetch_valid=0. Only step with sel=11 is acted on: pc←start_addr, go to FETCH. Any other step sets seq_err.
  - FETCH: fetch_valid=1, fetch_addr=pc. On fetch_valid && fetch_ready, go to EXEC.
  - EXEC: fetch_valid=0, waiting for step. On step, pc←next per sel, go to FETCH.
- Restart (sel=11 with step) is accepted in every state, including FETCH.
  - In FETCH it aborts the outstanding request; the fetch is not completed even if fetch_ready is high that cycle.
  - It clears seq_err, stack_err and the stack.
- A step in FETCH with sel≠11 is ignored and sets seq_err. pc is unchanged.
- fetch_addr is stable while fetch_valid=1 and fetch_ready=0.
- ret has priority over sel when both are present (stack enabled). call is ignored unless sel=01.

## Timing
- Reset values: pc=0, fetch_addr=0, fetch_valid=0, busy=0, seq_err=0, stack_err=0, stack empty, state IDLE.
- Reset mid-fetch drops the request immediately (asynchronous).
- Step accepted on edge N: new pc and fetch_valid=1 are visible in cycle N+1.
- Zero-wait memory (fetch_ready tied high): one FETCH cycle, then EXEC. Fastest instruction rate is one step every 2 cycles.
- No combinational path from step, s0/s1 or address inputs to any output. All outputs are registered.
- fetch_valid may only fall after a handshake, a restart, or reset.

## Configuration
- Macro `PC_SEQ_STACK_EN`.
- Defined:
  - step with call and sel=01 pushes pc+1, then branches.
  - step with ret pops into pc.
  - Push when full: push dropped, branch still taken, stack_err set.
  - Pop when empty: pc←pc+1, stack_err set.
- Undefined:
  - call and ret are ignored.
  - stack_err is tied 0.
  - No stack storage is built.
  - STACK_DEPTH is unused.

## Structure
- Package `pc_seq_pkg` holds:
  - sel encoding constants SEL_INC, SEL_BRANCH, SEL_INDIRECT, SEL_START;
  - state enum {IDLE, FETCH, EXEC}.
- Sub-module `pc_ret_stack` (push/pop/clear, full/empty, data out) is instantiated only under `PC_SEQ_STACK_EN`.

## Test plan
- Reset, then step sel=11 with start_addr=0x10, fetch_ready=1 → next cycle fetch_valid=1, fetch_addr=0x10; following cycle EXEC, busy=1.
- In EXEC with pc=0xFF (ADDR_W=8), step sel=00 → pc=0x00, fetch issued at 0x00.
- fetch_ready held low 3 cycles at pc=0x22 → fetch_valid and fetch_addr=0x22 held stable; EXEC entered the cycle after fetch_ready rises.
- In FETCH at pc=0x30, step sel=01, branch_addr=0x40 → ignored, seq_err=1, pc=0x30. Then step sel=11, start_addr=0x05 → seq_err=0, fetch_addr=0x05.
- Stack enabled: at pc=0x12, call with branch_addr=0x50 → pc=0x50; later ret → pc=0x13. Five nested calls with STACK_DEPTH=4 → stack_err=1 on the fifth, its branch still taken.
- Assert rst_n low while fetch_valid=1 → fetch_valid=0 and pc=0 immediately, state IDLE.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: select encodings and FSM states shared by the pc sequencer files
package pc_seq_pkg;
  localparam logic [1:0] SEL_INC      = 2'b00;
  localparam logic [1:0] SEL_BRANCH   = 2'b01;
  localparam logic [1:0] SEL_INDIRECT = 2'b10;
  localparam logic [1:0] SEL_START    = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2} state_t;
endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: LIFO of return addresses with synchronous clear, full/empty flags and a top-of-stack read
module pc_ret_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] top_idx;
  assign top_idx = cnt - CW'(1);
  assign dout = mem[top_idx[AW-1:0]];
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  // occupancy: clear wins, push and pop are never requested together
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (push) cnt <= cnt + CW'(1);
    else if (pop) cnt <= cnt - CW'(1);
  // storage needs no reset: entries are only read below the count
  always_ff @(posedge clk)
    if (push) mem[cnt[AW-1:0]] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: microsequencer PC and fetch handshake; define PC_SEQ_STACK_EN for the call/return stack
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s1,
  input  logic              s0,
  input  logic              step,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [ADDR_W-1:0] indirect_addr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              call,
  input  logic              ret,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              seq_err,
  output logic              stack_err
);
  state_t state;
  logic [1:0] sel;
  logic [ADDR_W-1:0] pc_inc, sel_next, next_pc;
  logic restart, exec_step;
  assign sel = {s1, s0};
  assign pc_inc = pc + ADDR_W'(1);
  assign exec_step = step && state == EXEC;
  assign sel_next = sel == SEL_BRANCH ? branch_addr : sel == SEL_INDIRECT ? indirect_addr : pc_inc;
`ifdef PC_SEQ_STACK_EN
  logic push, pop, full, empty, stk_fault;
  logic [ADDR_W-1:0] top;
  assign restart = step && sel == SEL_START && !ret;
  assign push = exec_step && !ret && call && sel == SEL_BRANCH && !full;
  assign pop = exec_step && ret && !empty;
  assign stk_fault = exec_step && (ret ? empty : call && sel == SEL_BRANCH && full);
  assign next_pc = ret ? (empty ? pc_inc : top) : sel_next;
  pc_ret_stack #(.ADDR_W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .rst_n(rst_n), .clear(restart), .push(push), .pop(pop),
    .din(pc_inc), .dout(top), .full(full), .empty(empty)
  );
  // sticky stack error, cleared only by restart
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stack_err <= 1'b0;
    else if (restart) stack_err <= 1'b0;
    else if (stk_fault) stack_err <= 1'b1;
`else
  logic unused_stack;
  assign unused_stack = ^{call, ret, STACK_DEPTH[0]};
  assign restart = step && sel == SEL_START;
  assign next_pc = sel_next;
  assign stack_err = 1'b0;
`endif
  // FSM, pc and sticky sequencing error; restart overrides everything including an in-flight fetch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      seq_err <= 1'b0;
    end else if (restart) begin
      state <= FETCH;
      pc <= start_addr;
      seq_err <= 1'b0;
    end else begin
      if (step && state != EXEC) seq_err <= 1'b1;
      if (state == FETCH && fetch_ready) state <= EXEC;
      if (exec_step) begin
        pc <= next_pc;
        state <= FETCH;
      end
    end
  assign fetch_valid = state == FETCH;
  assign fetch_addr = pc;
  assign busy = state != IDLE;
endmodule
